// File: rtl/regfile_sb_if.sv
// Register-file access bundle: read, writeback, issue and flush signals.
// master = pipeline side (decoder/hazard/writeback), slave = register file.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            init_done;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy1;
  logic            busy2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            sb_flush;

  modport master (
    input  init_done, rd1, rd2, busy1, busy2,
    output ra1, ra2, we, wa, wd,
    output iss_valid, iss_rd, sb_flush
  );

  modport slave (
    output init_done, rd1, rd2, busy1, busy2,
    input  ra1, ra2, we, wa, wd,
    input  iss_valid, iss_rd, sb_flush
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file: 2 async read ports, 1 write port, optional
// write-to-read bypass, per-register pending scoreboard.
// Ports: clk, rst (async, active-high), rf (regfile_sb_if.slave):
//   init_done, ra1/ra2 -> rd1/rd2 + busy1/busy2, we/wa/wd writeback,
//   iss_valid/iss_rd issue, sb_flush.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave rf
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]   cnt_q, cnt_d;
  logic            done_q;
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] sb_q, sb_d;

  logic            ready;
  logic            we_eff;
  logic            wa_zero;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic            hit1, hit2;

  assign ready   = (state_q == S_READY);
  assign wa_zero = ZERO_REG && (rf.wa == '0);
  assign we_eff  = ready && rf.we;

  // Sweep FSM and array write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == S_READY);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = rf.wa;
    mem_wd  = rf.wd;
    unique case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = S_READY;
      end
      S_READY: begin
        mem_we = rf.we && !wa_zero;
      end
      default: state_d = S_INIT;
    endcase
  end

  // No reset on the array so it can map to distributed RAM
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  // Scoreboard: set beats clear, flush beats set
  always_comb begin
    sb_d = sb_q;
    if (rf.we)
      sb_d[rf.wa] = 1'b0;
    if (rf.iss_valid)
      sb_d[rf.iss_rd] = 1'b1;
    if (rf.sb_flush)
      sb_d = '0;
    if (ZERO_REG)
      sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb_q <= '0;
    else if (ready)
      sb_q <= sb_d;
  end

  // Read ports
  assign hit1 = BYPASS && we_eff && !wa_zero
                && (rf.wa == rf.ra1);
  assign hit2 = BYPASS && we_eff && !wa_zero
                && (rf.wa == rf.ra2);

  always_comb begin
    rf.rd1 = '0;
    if (!ready)
      rf.rd1 = '0;
    else if (ZERO_REG && rf.ra1 == '0)
      rf.rd1 = '0;
    else if (hit1)
      rf.rd1 = rf.wd;
    else
      rf.rd1 = mem[rf.ra1];
  end

  always_comb begin
    rf.rd2 = '0;
    if (!ready)
      rf.rd2 = '0;
    else if (ZERO_REG && rf.ra2 == '0)
      rf.rd2 = '0;
    else if (hit2)
      rf.rd2 = rf.wd;
    else
      rf.rd2 = mem[rf.ra2];
  end

  // A writeback in flight satisfies the hazard this cycle
  assign rf.busy1 = ready && sb_q[rf.ra1] && !(BYPASS && we_eff && rf.wa == rf.ra1);
  assign rf.busy2 = ready && sb_q[rf.ra2] && !(BYPASS && we_eff && rf.wa == rf.ra2);

  assign rf.init_done = done_q;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined core generation: two asynchronous read ports, one write port, optional write-to-read bypass, and an integrated per-register pending scoreboard for hazard detection. Storage is initialised by a post-reset sweep FSM rather than a parallel reset, so the array can map to distributed RAM. Sits in decode/writeback, between the instruction decoder, the hazard unit and the writeback mux.

Parameters:
XLEN, 32, data width in bits (8..64)
NREGS, 32, number of architectural registers (power of two, 4..64)
AW, $clog2(NREGS), address width (derived, not overridden)
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports and masks the busy flags
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never marked busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
init_done  out  1  high once the initialisation sweep has finished; all other ports are valid only when high
ra1  in  AW  read address 1 (rs1)
ra2  in  AW  read address 2 (rs2)
rd1  out  XLEN  read data 1 (combinational)
rd2  out  XLEN  read data 2 (combinational)
busy1  out  1  scoreboard pending flag for ra1 (combinational)
busy2  out  1  scoreboard pending flag for ra2 (combinational)
we  in  1  writeback enable
wa  in  AW  writeback address
wd  in  XLEN  writeback data
iss_valid  in  1  an instruction writing iss_rd is issued this cycle
iss_rd  in  AW  destination register of the issued instruction
sb_flush  in  1  clears all pending flags (pipeline flush)

Behaviour:
- Reset (asynchronous): FSM enters INIT, sweep counter = 0, init_done = 0, all scoreboard bits = 0. The storage array is not reset.
- INIT state: each cycle writes 0 to entry[counter], then increments the counter. After writing entry NREGS-1 (NREGS cycles in total), the FSM moves to READY. init_done is registered and rises on the first READY cycle.
- During INIT: we, iss_valid and sb_flush are ignored; rd1, rd2 = 0; busy1, busy2 = 0.
- READY state: stays there until rst.
- Reset asserted mid-operation: returns to INIT and the full sweep repeats. Array contents are overwritten by the sweep.

Write rule:
- On a rising edge in READY with we = 1, entry[wa] <= wd.
- With ZERO_REG = 1, writes to wa = 0 are dropped.

Read rule (combinational):
- rdN = 0 if ZERO_REG and raN = 0.
- Otherwise, rdN = wd if BYPASS and we and wa = raN (and not (ZERO_REG and wa = 0)).
- Otherwise, rdN = entry[raN].

Scoreboard (one bit per register, updated on rising edge in READY):
- Writeback with we = 1 clears sb[wa].
- iss_valid = 1 sets sb[iss_rd].
- Same register set and cleared in the same cycle: set wins (a newer producer exists).
- sb_flush = 1 clears all bits and overrides any set in that cycle.
- With ZERO_REG = 1, sb[0] is constantly 0.

Busy outputs:
- busyN = sb[raN], masked to 0 when BYPASS and we and wa = raN.
- With BYPASS = 0 there is no masking. The consumer must stall one extra cycle.

Latency: read 0 cycles; write visible to a non-bypassed read on the next cycle.

Widths: no arithmetic. Addresses are used modulo NREGS, and AW covers exactly NREGS.

Test Plan:
- Reset then idle, defaults -> init_done stays 0 for exactly 32 cycles, rises on cycle 33; reads of every address return 0; busy1 = busy2 = 0 throughout.
- READY, write wa = 5, wd = 0xDEADBEEF with ra1 = 5 -> BYPASS = 1: rd1 = 0xDEADBEEF in the same cycle. BYPASS = 0: rd1 = old value (0) that cycle and 0xDEADBEEF the next cycle.
- Write wa = 0, wd = 0x12345678, then read ra2 = 0 -> rd2 = 0. Issue iss_rd = 0 -> busy2 stays 0.
- Issue iss_rd = 7 -> busy1 (ra1 = 7) = 1 next cycle. Writeback wa = 7 and issue iss_rd = 7 in the same cycle -> busy1 stays 1 after the edge (masked to 0 only during the writeback cycle when BYPASS = 1).
- Set busy on registers 3, 9, 31, then assert sb_flush together with iss_valid iss_rd = 9 -> next cycle all three flags read 0.
- Assert rst mid-stream with registers written and busy set -> init_done drops immediately, reads return 0 during the 32-cycle sweep; after init_done, register 5 reads 0 and all busy flags are 0.
